// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master, one-slave round-robin arbiter for the single-port
// program/data memory, with a slave-ack timeout that turns into an error response.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    // master 0: CPU load/store port
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic                    m0_ack,
    output logic                    m0_err,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    // master 1: UART loader / DMA engine
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_ack,
    output logic                    m1_err,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    // memory side
    output logic                    s_rd,
    output logic                    s_wr,
    output logic [ADDR_WIDTH-1:0]   s_addr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic                    s_ack
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    logic any_req;
    logic pick;
    logic timeout_hit;

    // On a tie the master that was not served last wins.
    assign any_req     = m0_req | m1_req;
    assign pick        = (m0_req & m1_req) ? ~last_grant_q : m1_req;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; s_ack beats a same-cycle timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (s_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: request latch, wait counter, response capture.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    we_d    = pick ? m1_we    : m0_we;
                    addr_d  = pick ? m1_addr  : m0_addr;
                    wdata_d = pick ? m1_wdata : m0_wdata;
                    wstrb_d = pick ? m1_wstrb : m0_wstrb;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (s_ack) begin
                    rdata_d = we_q ? '0 : s_rdata;
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                last_grant_d = grant_q;
                cnt_d        = '0;
                err_d        = 1'b0;
                rdata_d      = '0;
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears everything visible on the slave side.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    // Outputs: strobes while BUSY, a single ack/err/rdata pulse to the granted master in RESP.
    always_comb begin
        s_rd     = 1'b0;
        s_wr     = 1'b0;
        s_addr   = addr_q;
        s_wdata  = wdata_q;
        s_wstrb  = wstrb_q;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m0_rdata = '0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        m1_rdata = '0;
        case (state_q)
            BUSY: begin
                s_rd = ~we_q;
                s_wr = we_q;
            end
            RESP: begin
                if (grant_q) begin
                    m1_ack   = 1'b1;
                    m1_err   = err_q;
                    m1_rdata = rdata_q;
                end else begin
                    m0_ack   = 1'b1;
                    m0_err   = err_q;
                    m0_rdata = rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level arbitration model.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [SW-1:0] m0_wstrb, m1_wstrb;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_rd, s_wr, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [SW-1:0] s_wstrb;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0_req  (m0_req),
        .m0_we   (m0_we),
        .m0_addr (m0_addr),
        .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb),
        .m0_ack  (m0_ack),
        .m0_err  (m0_err),
        .m0_rdata(m0_rdata),
        .m1_req  (m1_req),
        .m1_we   (m1_we),
        .m1_addr (m1_addr),
        .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb),
        .m1_ack  (m1_ack),
        .m1_err  (m1_err),
        .m1_rdata(m1_rdata),
        .s_rd    (s_rd),
        .s_wr    (s_wr),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ack   (s_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Master-side model: outstanding request per master and its fields.
    bit            pend[2];
    bit            req_drv[2];
    logic          we_m[2];
    logic [AW-1:0] addr_m[2];
    logic [DW-1:0] wdata_m[2];
    logic [SW-1:0] wstrb_m[2];
    int            last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        m0_req   = req_drv[0];
        m0_we    = we_m[0];
        m0_addr  = addr_m[0];
        m0_wdata = wdata_m[0];
        m0_wstrb = wstrb_m[0];
        m1_req   = req_drv[1];
        m1_we    = we_m[1];
        m1_addr  = addr_m[1];
        m1_wdata = wdata_m[1];
        m1_wstrb = wstrb_m[1];
    endtask

    task automatic set_req(input int m, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [SW-1:0] st);
        pend[m]    = 1'b1;
        req_drv[m] = 1'b1;
        we_m[m]    = we;
        addr_m[m]  = a;
        wdata_m[m] = wd;
        wstrb_m[m] = st;
    endtask

    task automatic gen(input int m);
        set_req(m, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
    endtask

    function automatic logic ack_of(input int m);
        return (m == 1) ? m1_ack : m0_ack;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 1) ? m1_err : m0_err;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int m);
        return (m == 1) ? m1_rdata : m0_rdata;
    endfunction

    task automatic chk_quiet(input string where);
        chk({where, ".s_rd"}, s_rd, 0);
        chk({where, ".s_wr"}, s_wr, 0);
        chk({where, ".m0_ack"}, m0_ack, 0);
        chk({where, ".m1_ack"}, m1_ack, 0);
    endtask

    task automatic chk_all_zero(input string where);
        chk_quiet(where);
        chk({where, ".m0_err"}, m0_err, 0);
        chk({where, ".m1_err"}, m1_err, 0);
        chk({where, ".m0_rdata"}, m0_rdata, 0);
        chk({where, ".m1_rdata"}, m1_rdata, 0);
        chk({where, ".s_addr"}, s_addr, 0);
        chk({where, ".s_wdata"}, s_wdata, 0);
        chk({where, ".s_wstrb"}, 32'(s_wstrb), 0);
    endtask

    // One arbitrated access. Entered and left in an IDLE cycle (#1 after the edge).
    // d = number of strobe cycles before the slave acks; rd = slave read data.
    task automatic run_txn(input int d, input logic [DW-1:0] rd, input bit perturb);
        int            w;
        int            n_str;
        bit            to_err;
        logic [DW-1:0] exp_rd;
        apply();
        chk_quiet("idle");
        if (pend[0] && pend[1]) w = 1 - last_g;
        else                    w = pend[1] ? 1 : 0;
        pend[w] = 1'b0;
        to_err  = (T != 0) && (d + 1 > T);
        n_str   = to_err ? T : d + 1;
        tick();
        for (int i = 1; i <= n_str; i++) begin
            chk("busy.s_rd", s_rd, !we_m[w]);
            chk("busy.s_wr", s_wr, we_m[w]);
            chk("busy.s_addr", s_addr, addr_m[w]);
            chk("busy.s_wdata", s_wdata, wdata_m[w]);
            chk("busy.s_wstrb", 32'(s_wstrb), 32'(wstrb_m[w]));
            chk("busy.m0_ack", m0_ack, 0);
            chk("busy.m1_ack", m1_ack, 0);
            if (perturb) begin
                if (!pend[1-w] && $urandom_range(0, 3) == 0) gen(1 - w);
                if ($urandom_range(0, 3) == 0) req_drv[w] = 1'b0;
            end
            s_ack   = (i == d + 1);
            s_rdata = (i == d + 1) ? rd : $urandom;
            apply();
            tick();
        end
        s_ack   = 1'b0;
        s_rdata = $urandom;
        exp_rd  = (to_err || we_m[w]) ? '0 : rd;
        chk("resp.ack_granted", ack_of(w), 1);
        chk("resp.err_granted", err_of(w), to_err);
        chk("resp.rdata_granted", rdata_of(w), exp_rd);
        chk("resp.ack_other", ack_of(1 - w), 0);
        chk("resp.err_other", err_of(1 - w), 0);
        chk("resp.rdata_other", rdata_of(1 - w), 0);
        chk("resp.s_rd", s_rd, 0);
        chk("resp.s_wr", s_wr, 0);
        last_g     = w;
        req_drv[w] = 1'b0;
        if (perturb && $urandom_range(0, 1) == 1) gen(w);
        apply();
        tick();
    endtask

    initial begin
        reset   = 1'b0;
        s_ack   = 1'b0;
        s_rdata = '0;
        for (int m = 0; m < 2; m++) begin
            pend[m]    = 1'b0;
            req_drv[m] = 1'b0;
            we_m[m]    = 1'b0;
            addr_m[m]  = '0;
            wdata_m[m] = '0;
            wstrb_m[m] = '0;
        end
        last_g = 1;
        apply();
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Simultaneous requests after reset: 0,1,0,1.
        set_req(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        run_txn(0, 32'hA000_0001, 1'b0);
        set_req(0, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
        run_txn(0, 32'hA000_0002, 1'b0);
        set_req(1, 1'b0, 32'h0000_0204, 32'h0, 4'hF);
        run_txn(1, 32'hA000_0003, 1'b0);
        run_txn(2, 32'hA000_0004, 1'b0);

        // Single read with one wait cycle.
        set_req(0, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        run_txn(1, 32'hDEAD_BEEF, 1'b0);

        // Partial-strobe write from master 1; rdata must come back zero.
        set_req(1, 1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0011);
        run_txn(0, 32'hFFFF_FFFF, 1'b0);

        // Hung slave: strobes for exactly T cycles then ack+err, then a normal access.
        set_req(0, 1'b0, 32'h0000_0030, 32'h0, 4'hF);
        run_txn(100, 32'h5555_5555, 1'b0);
        set_req(1, 1'b0, 32'h0000_0034, 32'h0, 4'hF);
        run_txn(2, 32'h0BAD_F00D, 1'b0);

        // s_ack on the timeout cycle wins over the timeout.
        set_req(0, 1'b0, 32'h0000_0038, 32'h0, 4'hF);
        run_txn(T - 1, 32'hCAFE_F00D, 1'b0);

        // Reset in the middle of a read: everything clears, no ack ever appears.
        set_req(0, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
        apply();
        tick();
        chk("midrst.s_rd_before", s_rd, 1);
        tick();
        reset   = 1'b0;
        s_ack   = 1'b1;
        s_rdata = 32'h7777_7777;
        tick();
        chk_all_zero("midrst");
        s_ack = 1'b0;
        tick();
        chk_all_zero("midrst_hold");
        reset  = 1'b1;
        pend[0] = 1'b0;
        req_drv[0] = 1'b0;
        last_g = 1;
        set_req(0, 1'b0, 32'h0000_0050, 32'h0, 4'hF);
        set_req(1, 1'b1, 32'h0000_0060, 32'hA5A5_5A5A, 4'b1100);
        run_txn(0, 32'h1111_2222, 1'b0);
        run_txn(1, 32'h3333_4444, 1'b0);

        // Randomized traffic with late requests, in-flight req drops and timeouts.
        for (int k = 0; k < 60; k++) begin
            if (!pend[0] && !pend[1]) begin
                if ($urandom_range(0, 2) == 0) begin
                    apply();
                    chk_quiet("rand_idle");
                    tick();
                end
                gen($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1) begin
                    if (!pend[0]) gen(0);
                    else if (!pend[1]) gen(1);
                end
            end
            run_txn($urandom_range(0, 10), $urandom, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            if (pend[0] || pend[1]) run_txn(0, $urandom, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
